// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: widths, RISC-V load/store
// funct3 codes, FSM encoding and the access legality rule.
package dmem_arbiter_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Natural alignment also guarantees a multi-byte access never wraps past the top address.
    function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                          input logic [ADDR_W-1:0] addr);
        logic ok;
        ok = 1'b0;
        if (we) begin
            case (f3)
                F3_SB:   ok = 1'b1;
                F3_SH:   ok = ~addr[0];
                F3_SW:   ok = (addr[1:0] == 2'b00);
                default: ok = 1'b0;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: ok = 1'b1;
                F3_LH, F3_LHU: ok = ~addr[0];
                F3_LW:         ok = (addr[1:0] == 2'b00);
                default:       ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
// Handshake: req is raised with we/funct3/addr/wdata and held until ack pulses
// for one cycle; err/rdata are valid with that ack. req may drop or change at
// the edge that ends the ack cycle.
interface dmem_arbiter_if;
    import dmem_arbiter_pkg::*;

    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic              err;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, funct3, addr, wdata, input ack, err, rdata);
    modport slave  (input req, we, funct3, addr, wdata, output ack, err, rdata);

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, favouring the port not served
// last when both request.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] grant
);

    logic last_grant;

    always_ff @(posedge clk) begin
        if (!rst)
            last_grant <= 1'b1;
        else if (upd && (grant != 2'b00))
            last_grant <= grant[1];
    end

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the shared byte-addressed data
// memory; illegal accesses are answered with err and never reach memory.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [2:0]        mem_funct3,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output state_t            state_dbg
);

    state_t state, state_nxt;

    logic [1:0]        req, grant;
    logic              grant_upd, any_grant;
    logic              win_port, win_we, win_legal;
    logic [2:0]        win_f3;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              lat_port, lat_we, lat_err;
    logic [2:0]        lat_f3;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              ack0, ack1, err0, err1;

    assign req       = {p1.req, p0.req};
    assign grant_upd = (state == ST_IDLE);
    assign any_grant = |grant;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .upd   (grant_upd),
        .grant (grant)
    );

    always_comb begin
        win_port  = grant[1];
        win_we    = grant[1] ? p1.we     : p0.we;
        win_f3    = grant[1] ? p1.funct3 : p0.funct3;
        win_addr  = grant[1] ? p1.addr   : p0.addr;
        win_wdata = grant[1] ? p1.wdata  : p0.wdata;
        win_legal = access_legal(win_we, win_f3, win_addr);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (any_grant) state_nxt = win_legal ? ST_ACCESS : ST_RESP;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request capture and read-data return; rejected grants clear rdata before their ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_f3    <= 3'b000;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (state == ST_IDLE && any_grant) begin
                lat_port  <= win_port;
                lat_we    <= win_we;
                lat_err   <= ~win_legal;
                lat_f3    <= win_f3;
                lat_addr  <= win_addr;
                lat_wdata <= win_wdata;
                if (!win_legal) begin
                    if (win_port) rdata1_q <= '0;
                    else          rdata0_q <= '0;
                end
            end
            if (state == ST_ACCESS) begin
                if (lat_port) rdata1_q <= lat_we ? '0 : mem_rdata;
                else          rdata0_q <= lat_we ? '0 : mem_rdata;
            end
        end
    end

    always_comb begin
        mem_funct3 = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        err0       = 1'b0;
        err1       = 1'b0;
        case (state)
            ST_ACCESS: begin
                mem_funct3 = lat_f3;
                mem_read   = ~lat_we;
                // Gated by reset so an aborted store never commits.
                mem_write  = lat_we & rst;
                mem_addr   = lat_addr;
                mem_wdata  = lat_wdata;
            end
            ST_RESP: begin
                ack0 = ~lat_port;
                ack1 = lat_port;
                err0 = ~lat_port & lat_err;
                err1 = lat_port & lat_err;
            end
            default: ;
        endcase
    end

    assign p0.ack   = ack0;
    assign p1.ack   = ack1;
    assign p0.err   = err0;
    assign p1.err   = err1;
    assign p0.rdata = rdata0_q;
    assign p1.rdata = rdata1_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural byte memory, transaction-level reference
// model (round-robin order, legality, load/store bytes) and directed/random steps.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  mem_funct3;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  state_t      state_dbg;

  dmem_arbiter_if p0_if ();
  dmem_arbiter_if p1_if ();

  dmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0_if),
    .p1         (p1_if),
    .mem_funct3 (mem_funct3),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  item_t q0[$];
  item_t q1[$];
  int model_last = 1;
  logic [31:0] last_rdata [2];
  int ack_order[$];

  function automatic logic [7:0] init_byte(int i);
    if (i == 0) return 8'd17;
    if (i < 4) return 8'd0;
    if (i >= 12 && i <= 15) return 8'hFF;
    return 8'((i * 37 + 11) & 255);
  endfunction

  // behavioural data memory: combinational read with extension, write at clock edge
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0 = mem_addr;
    a1 = mem_addr + 8'd1;
    a2 = mem_addr + 8'd2;
    a3 = mem_addr + 8'd3;
    case (mem_funct3)
      3'b000:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b010:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b100:  mem_rdata = {24'd0, mem[a0]};
      3'b101:  mem_rdata = {16'd0, mem[a1], mem[a0]};
      default: mem_rdata = 32'd0;
    endcase
  end

  initial begin
    logic        wr_pend;
    logic [2:0]  wr_f3;
    logic [7:0]  wr_a;
    logic [31:0] wr_d;
    for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      wr_pend = mem_write;
      wr_f3 = mem_funct3;
      wr_a = mem_addr;
      wr_d = mem_wdata;
      @(posedge clk);
      if (wr_pend) begin
        for (int i = 0; i < (1 << wr_f3[1:0]); i++) mem[8'(wr_a + 8'(i))] = wr_d[8*i +: 8];
      end
    end
  end

  // reference model
  function automatic bit model_legal(item_t it);
    int size;
    if (it.we) begin
      if (it.f3 > 3'd2) return 0;
    end else if (!(it.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) begin
      return 0;
    end
    size = 1 << it.f3[1:0];
    return (int'(it.addr) % size) == 0;
  endfunction

  function automatic logic [31:0] model_load(item_t it);
    int size;
    logic [31:0] v;
    size = 1 << it.f3[1:0];
    v = 0;
    for (int i = 0; i < size; i++) v = v | (32'(ref_mem[(int'(it.addr) + i) % 256]) << (8 * i));
    if (!it.f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
    return v;
  endfunction

  function automatic void model_store(item_t it);
    for (int i = 0; i < (1 << it.f3[1:0]); i++)
      ref_mem[(int'(it.addr) + i) % 256] = it.wdata[8*i +: 8];
  endfunction

  function automatic item_t mk(logic we, logic [2:0] f3, logic [7:0] a, logic [31:0] d);
    item_t it;
    it.we = we; it.f3 = f3; it.addr = a; it.wdata = d;
    return it;
  endfunction

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drivers
  task automatic put(input int p);
    if (p == 0) begin
      if (q0.size() > 0) begin
        p0_if.req = 1'b1; p0_if.we = q0[0].we; p0_if.funct3 = q0[0].f3;
        p0_if.addr = q0[0].addr; p0_if.wdata = q0[0].wdata;
      end else p0_if.req = 1'b0;
    end else begin
      if (q1.size() > 0) begin
        p1_if.req = 1'b1; p1_if.we = q1[0].we; p1_if.funct3 = q1[0].f3;
        p1_if.addr = q1[0].addr; p1_if.wdata = q1[0].wdata;
      end else p1_if.req = 1'b0;
    end
  endtask

  task automatic mem_image_chk(input string tag);
    int diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk(tag, 32'(diffs), 32'd0);
  endtask

  // runs everything queued on both ports, checking each ack against the model
  task automatic run_txns();
    int cyc = 0, prev_ack = -1, strobes = 0, exp_strobes = 0, p, exp_port, lat, budget;
    item_t cur;
    logic legal;
    logic [31:0] exp_rd;
    budget = 10 * (q0.size() + q1.size()) + 10;
    ack_order.delete();
    put(0);
    put(1);
    while ((q0.size() > 0 || q1.size() > 0) && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_read || mem_write) strobes++;
      if (p0_if.ack || p1_if.ack) begin
        chk("dual_ack", 32'(p0_if.ack & p1_if.ack), 32'd0);
        p = p1_if.ack ? 1 : 0;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
          chk("spurious_ack", 32'(p), 32'hFFFF_FFFF);
        end else begin
          exp_port = (q0.size() > 0 && q1.size() > 0) ? 1 - model_last : (q0.size() > 0 ? 0 : 1);
          chk("grant_port", 32'(p), 32'(exp_port));
          cur = (p == 0) ? q0[0] : q1[0];
          legal = model_legal(cur);
          lat = legal ? 2 : 1;
          if (legal) exp_strobes++;
          chk("ack_cycle", 32'(cyc), 32'(prev_ack + 1 + lat));
          chk("err", 32'(p ? p1_if.err : p0_if.err), 32'(!legal));
          exp_rd = (!legal || cur.we) ? 32'd0 : model_load(cur);
          chk("rdata", p ? p1_if.rdata : p0_if.rdata, exp_rd);
          if (legal && cur.we) model_store(cur);
          last_rdata[p] = exp_rd;
          model_last = p;
          ack_order.push_back(p);
          prev_ack = cyc;
          if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          put(p);
        end
      end
    end
    chk("drained", 32'(q0.size() + q1.size()), 32'd0);
    q0.delete(); q1.delete();
    p0_if.req = 1'b0; p1_if.req = 1'b0;
    @(posedge clk); #1;
    chk("back_to_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("rdata0_hold", p0_if.rdata, last_rdata[0]);
    chk("rdata1_hold", p1_if.rdata, last_rdata[1]);
    chk("mem_strobes", 32'(strobes), 32'(exp_strobes));
    mem_image_chk("mem_image");
  endtask

  task automatic one(input int p, input item_t it);
    if (p == 0) q0.push_back(it); else q1.push_back(it);
    run_txns();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    last_rdata[0] = 0; last_rdata[1] = 0;
    p0_if.req = 0; p0_if.we = 0; p0_if.funct3 = 0; p0_if.addr = 0; p0_if.wdata = 0;
    p1_if.req = 0; p1_if.we = 0; p1_if.funct3 = 0; p1_if.addr = 0; p1_if.wdata = 0;
    rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack0", 32'(p0_if.ack), 0);
    chk("rst_ack1", 32'(p1_if.ack), 0);
    chk("rst_err0", 32'(p0_if.err), 0);
    chk("rst_err1", 32'(p1_if.err), 0);
    chk("rst_rdata0", p0_if.rdata, 0);
    chk("rst_rdata1", p1_if.rdata, 0);
    chk("rst_mem_ctl", {mem_funct3, mem_read, mem_write, mem_addr}, 0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1;
    @(posedge clk); #1;

    // word load
    one(0, mk(0, F3_LW, 8'd0, 0));
    chk("lw_addr0", p0_if.rdata, 32'h0000_0011);

    // sign / zero extension
    one(0, mk(0, F3_LB, 8'd12, 0));
    chk("lb_ff", p0_if.rdata, 32'hFFFF_FFFF);
    one(0, mk(0, F3_LBU, 8'd12, 0));
    chk("lbu_ff", p0_if.rdata, 32'h0000_00FF);
    one(0, mk(0, F3_LHU, 8'd12, 0));
    chk("lhu_ffff", p0_if.rdata, 32'h0000_FFFF);

    // store then load on port 1
    one(1, mk(1, F3_SW, 8'd40, 32'hDEAD_BEEF));
    one(1, mk(0, F3_LW, 8'd40, 0));
    chk("sw_lw", p1_if.rdata, 32'hDEAD_BEEF);
    one(1, mk(1, F3_SB, 8'd41, 32'h0000_005A));
    one(1, mk(0, F3_LW, 8'd40, 0));
    chk("sb_lw", p1_if.rdata, 32'hDEAD_5AEF);

    // contention: both ports held with two loads each
    q0.push_back(mk(0, F3_LW, 8'd0, 0));
    q0.push_back(mk(0, F3_LW, 8'd40, 0));
    q1.push_back(mk(0, F3_LB, 8'd12, 0));
    q1.push_back(mk(0, F3_LHU, 8'd40, 0));
    run_txns();
    chk("contention_order", (ack_order.size() == 4) ?
        32'({ack_order[0][3:0], ack_order[1][3:0], ack_order[2][3:0], ack_order[3][3:0]}) : 32'hFFFF,
        32'h0101);

    // illegal accesses
    one(0, mk(0, F3_LW, 8'd254, 0));
    chk("ill_lw254_rd", p0_if.rdata, 0);
    one(1, mk(1, F3_SH, 8'd3, 32'hCAFE_F00D));
    chk("ill_sh3_rd", p1_if.rdata, 0);
    one(0, mk(0, 3'b011, 8'd0, 0));
    chk("ill_f3_011_rd", p0_if.rdata, 0);

    // reset during the ACCESS cycle of a store
    q1.push_back(mk(1, F3_SW, 8'd44, 32'h1234_5678));
    put(1);
    @(posedge clk); #1;
    chk("abort_in_access", 32'(state_dbg), 32'(ST_ACCESS));
    chk("abort_wr_before", 32'(mem_write), 1);
    rst = 0;
    #1;
    chk("abort_wr_gated", 32'(mem_write), 0);
    @(posedge clk); #1;
    q1.delete();
    p1_if.req = 0;
    chk("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("abort_outs", {p0_if.ack, p1_if.ack, p0_if.err, p1_if.err, mem_read, mem_write}, 0);
    chk("abort_rdata", p0_if.rdata | p1_if.rdata, 0);
    @(posedge clk); #1;
    rst = 1;
    model_last = 1;
    last_rdata[0] = 0; last_rdata[1] = 0;
    @(posedge clk); #1;
    mem_image_chk("abort_mem");

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      for (int p = 0; p < 2; p++) begin
        int n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          logic [7:0] a;
          a = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 1) == 1) a = a & 8'hFC;
          if (p == 0) q0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom));
          else        q1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom));
        end
      end
      run_txns();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
